// File: rtl/mtime_counter_if.sv
// mtime_counter_if: peripheral bus bundle between a bus master and the mtime counter
interface mtime_counter_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic        mem_re;
    modport master (output mem_addr, output mem_wdata, output mem_we, output mem_re, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_we, input mem_re, output mem_rdata);
endinterface

// File: rtl/mtime_counter.sv
// mtime_counter: 48-bit prescaled machine-time source with memory-mapped control.
// Optional MTIME_READ_LATCH_EN: a MTIME_LO read snapshots mtime[47:32] so a following
// MTIME_HI read is coherent across a low-word carry.
module mtime_counter #(
    parameter logic [31:0] COUNTER_BASE_ADDR = 32'h40003000,
    parameter logic        RESET_ENABLE      = 1'b1,
    parameter logic [15:0] PRESCALE_RESET    = 16'd0
) (
    input  logic               clk,
    input  logic               rst,
    mtime_counter_if.slave     bus,
    output logic [47:0]        mtime,
    output logic               mtime_tick
);
    logic [47:0] mtime_q, mtime_d;
    logic [15:0] ps_cnt_q, ps_cnt_d;
    logic [15:0] prescale_q, prescale_d;
    logic        en_q, en_d;
    logic        tick_q, tick_d;
    logic        sel, rd_sel;
    logic [3:0]  off;
    logic        wr_lo, wr_hi, wr_ctrl, wr_ps, clr, inc, mt_wr;
    logic [15:0] hi_rd;
    logic        unused;
`ifdef MTIME_READ_LATCH_EN
    logic [15:0] hi_latch_q, hi_latch_d;
`endif

    assign unused = &{1'b0, bus.mem_addr[7:4], bus.mem_wdata[31:16]};

    // address decode and write strobes for each register
    always_comb begin
        sel     = bus.mem_addr[31:8] == COUNTER_BASE_ADDR[31:8];
        off     = bus.mem_addr[3:0];
        rd_sel  = sel && bus.mem_re;
        wr_lo   = sel && bus.mem_we && off == 4'h0;
        wr_hi   = sel && bus.mem_we && off == 4'h4;
        wr_ctrl = sel && bus.mem_we && off == 4'h8;
        wr_ps   = sel && bus.mem_we && off == 4'hC;
        clr     = wr_ctrl && bus.mem_wdata[1];
        mt_wr   = wr_lo || wr_hi || clr;
        inc     = en_q && ps_cnt_q == prescale_q;
    end

    // next-state: bus writes and clear take priority over the prescaled increment
    always_comb begin
        mtime_d    = clr   ? 48'h0 :
                     wr_lo ? {mtime_q[47:32], bus.mem_wdata} :
                     wr_hi ? {bus.mem_wdata[15:0], mtime_q[31:0]} :
                     inc   ? mtime_q + 48'h1 : mtime_q;
        ps_cnt_d   = (mt_wr || wr_ps) ? 16'h0 :
                     !en_q            ? ps_cnt_q :
                     inc              ? 16'h0 : ps_cnt_q + 16'h1;
        tick_d     = inc && !mt_wr;
        en_d       = wr_ctrl ? bus.mem_wdata[0] : en_q;
        prescale_d = wr_ps ? bus.mem_wdata[15:0] : prescale_q;
    end

`ifdef MTIME_READ_LATCH_EN
    // snapshot the high word on a low-word read; any mtime rewrite invalidates it
    always_comb begin
        hi_latch_d = mt_wr                   ? 16'h0 :
                     (rd_sel && off == 4'h0) ? mtime_q[47:32] : hi_latch_q;
        hi_rd      = hi_latch_q;
    end
`else
    assign hi_rd = mtime_q[47:32];
`endif

    // register state; reset overrides any same-cycle bus write
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q    <= 48'h0;
            ps_cnt_q   <= 16'h0;
            prescale_q <= PRESCALE_RESET;
            en_q       <= RESET_ENABLE;
            tick_q     <= 1'b0;
`ifdef MTIME_READ_LATCH_EN
            hi_latch_q <= 16'h0;
`endif
        end else begin
            mtime_q    <= mtime_d;
            ps_cnt_q   <= ps_cnt_d;
            prescale_q <= prescale_d;
            en_q       <= en_d;
            tick_q     <= tick_d;
`ifdef MTIME_READ_LATCH_EN
            hi_latch_q <= hi_latch_d;
`endif
        end
    end

    // combinational read mux; CLR always reads back as zero
    always_comb begin
        bus.mem_rdata = !rd_sel      ? 32'h0 :
                        off == 4'h0  ? mtime_q[31:0] :
                        off == 4'h4  ? {16'h0, hi_rd} :
                        off == 4'h8  ? {31'h0, en_q} :
                        off == 4'hC  ? {16'h0, prescale_q} : 32'h0;
    end

    assign mtime      = mtime_q;
    assign mtime_tick = tick_q;
endmodule
